mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mdr_reg.sv | 31 +++
 rtl/mem_access_ctrl.sv | 116 +++++++++++
 tb/tb_mem_access_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory access controller.
package mem_pkg;

  localparam int DATA_W          = 32;
  localparam int ADDR_W_DEF      = 9;
  localparam int WAIT_CYCLES_DEF = 2;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // Counter preload so that ACCESS spans exactly wait_cycles cycles.
  function automatic logic [CNT_W-1:0] wait_load(input int wait_cycles);
    return CNT_W'(wait_cycles - 1);
  endfunction

endpackage

// File: rtl/mdr_reg.sv
// Memory data register: loads either the datapath bus or RAM read data.
module mdr_reg
  import mem_pkg::*;
(
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              sel_mem_i,
  input  logic [DATA_W-1:0] bus_i,
  input  logic [DATA_W-1:0] mem_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] mdr_q;
  logic [DATA_W-1:0] mdr_d;

  always_comb begin
    mdr_d = sel_mem_i ? mem_i : bus_i;
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      mdr_q <= '0;
    end else if (load_i) begin
      mdr_q <= mdr_d;
    end
  end

  assign q_o = mdr_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences a single RAM read or write with a programmable strobe width,
// owning the MAR and MDR that sit between the datapath bus and the RAM.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int ADDR_W      = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  input  logic [DATA_W-1:0] Mdatain,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_read,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] MDR_q,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] CNT_LOAD = wait_load(WAIT_CYCLES);

  state_e            state_q;
  logic [ADDR_W-1:0] mar_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              op_rd_q;
  logic              ram_read_q;
  logic              ram_write_q;
  logic              busy_q;
  logic              done_q;

  logic              regs_open;
  logic              rd_capture;
  logic              mdr_load;

  // MAR/MDR are only writable from the bus while no access is in flight.
  always_comb begin
    regs_open  = (state_q == S_IDLE) || (state_q == S_DONE);
    rd_capture = (state_q == S_ACCESS) && (cnt_q == '0) && op_rd_q;
    mdr_load   = (regs_open && MDRin) || rd_capture;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= S_IDLE;
      mar_q       <= '0;
      cnt_q       <= '0;
      op_rd_q     <= 1'b0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (regs_open && MARin) begin
        mar_q <= BusMuxOut[ADDR_W-1:0];
      end
      case (state_q)
        S_IDLE: begin
          if (Read || Write) begin
            state_q <= S_SETUP;
            op_rd_q <= Read;
            busy_q  <= 1'b1;
          end
        end
        S_SETUP: begin
          state_q     <= S_ACCESS;
          cnt_q       <= CNT_LOAD;
          ram_read_q  <= op_rd_q;
          ram_write_q <= !op_rd_q;
        end
        S_ACCESS: begin
          if (cnt_q == '0) begin
            state_q     <= S_DONE;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  mdr_reg u_mdr (
    .clk_i     (clk),
    .clr_i     (clr),
    .load_i    (mdr_load),
    .sel_mem_i (rd_capture),
    .bus_i     (BusMuxOut),
    .mem_i     (Mdatain),
    .q_o       (MDR_q)
  );

  assign ram_address = mar_q;
  assign ram_wdata   = MDR_q;
  assign ram_read    = ram_read_q;
  assign ram_write   = ram_write_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: default instance plus a WAIT_CYCLES=1 instance.
module tb_mem_access_ctrl;

  localparam int W0 = 2;
  localparam int W1 = 1;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
    int          due;
    bit          wr;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] bus = '0;
  logic        marin0 = 0, mdrin0 = 0, rd0 = 0, wr0 = 0;
  logic        marin1 = 0, mdrin1 = 0, rd1 = 0, wr1 = 0;
  logic [31:0] mdat0, mdat1, wdat0, wdat1, mdr0, mdr1;
  logic [8:0]  addr0, addr1;
  logic        rrd0, rwr0, busy0, done0;
  logic        rrd1, rwr1, busy1, done1;

  logic [31:0] ram0 [512];
  logic [31:0] ram1 [512];

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   ovl   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rwr0) ram0[addr0] <= wdat0;
  always @(posedge clk) if (rwr1) ram1[addr1] <= wdat1;
  assign mdat0 = ram0[addr0];
  assign mdat1 = ram1[addr1];

  always @(negedge clk) if ((rrd0 && rwr0) || (rrd1 && rwr1)) ovl <= ovl + 1;

  mem_access_ctrl #(.WAIT_CYCLES(W0), .ADDR_W(9)) dut0 (
    .clk(clk), .clr(clr), .BusMuxOut(bus), .MARin(marin0), .MDRin(mdrin0),
    .Read(rd0), .Write(wr0), .Mdatain(mdat0), .ram_address(addr0),
    .ram_read(rrd0), .ram_write(rwr0), .ram_wdata(wdat0), .MDR_q(mdr0),
    .busy(busy0), .done(done0)
  );

  mem_access_ctrl #(.WAIT_CYCLES(W1), .ADDR_W(9)) dut1 (
    .clk(clk), .clr(clr), .BusMuxOut(bus), .MARin(marin1), .MDRin(mdrin1),
    .Read(rd1), .Write(wr1), .Mdatain(mdat1), .ram_address(addr1),
    .ram_read(rrd1), .ram_write(rwr1), .ram_wdata(wdat1), .MDR_q(mdr1),
    .busy(busy1), .done(done1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_cmp++; if (addr0 !== 9'h0) begin n_err++; $display("FAIL reset_addr got %h want 000", addr0); end
    n_cmp++; if ({rrd0, rwr0, busy0, done0} !== 4'b0) begin n_err++; $display("FAIL reset_ctl got %b want 0000", {rrd0, rwr0, busy0, done0}); end
    n_cmp++; if (mdr0 !== 32'h0) begin n_err++; $display("FAIL reset_mdr got %h want 00000000", mdr0); end
    n_cmp++; if ({busy1, done1, mdr1} !== 34'h0) begin n_err++; $display("FAIL reset_dut1 got %h want 0", {busy1, done1, mdr1}); end
  endtask

  task automatic test_read();
    exp_t e;
    int   s;
    ram0[9'h055] = 32'hDEAD_BEEF;
    bus = 32'h0000_0055; marin0 = 1; rd0 = 1;
    tick();
    s = cyc; marin0 = 0; rd0 = 0;
    sbq.push_back('{addr: 9'h055, data: 32'hDEAD_BEEF, due: s + W0 + 1, wr: 1'b0});
    for (int i = 1; i <= W0 + 3; i++) begin
      n_cmp++;
      if (rrd0 !== (i >= 2 && i <= W0 + 1)) begin n_err++; $display("FAIL read_strobe cyc%0d got %b", i, rrd0); end
      if (done0) begin
        n_cmp++;
        if (sbq.size() == 0) begin n_err++; $display("FAIL read_extra_done at cyc%0d", i); end
        else begin
          e = sbq.pop_front();
          if (cyc !== e.due || mdr0 !== e.data) begin
            n_err++; $display("FAIL read_done got cyc %0d mdr %h want cyc %0d mdr %h", cyc, mdr0, e.due, e.data);
          end
        end
      end
      tick();
    end
    n_cmp++; if (sbq.size() != 0) begin n_err++; $display("FAIL read_no_done got %0d pending want 0", sbq.size()); void'(sbq.pop_front()); end
  endtask

  task automatic test_write();
    exp_t e;
    int   s, wcnt, ndone;
    bus = 32'h0000_01FF; marin0 = 1;
    tick();
    marin0 = 0;
    bus = 32'h1234_5678; mdrin0 = 1; wr0 = 1;
    tick();
    s = cyc; mdrin0 = 0; wr0 = 0; wcnt = 0; ndone = 0;
    sbq.push_back('{addr: 9'h1FF, data: 32'h1234_5678, due: s + W0 + 1, wr: 1'b1});
    for (int i = 1; i <= W0 + 3; i++) begin
      if (rwr0) begin
        wcnt++;
        n_cmp++; if (addr0 !== 9'h1FF) begin n_err++; $display("FAIL write_addr got %h want 1ff", addr0); end
      end
      if (done0) begin
        ndone++;
        n_cmp++;
        if (sbq.size() == 0) begin n_err++; $display("FAIL write_extra_done at cyc%0d", i); end
        else begin
          e = sbq.pop_front();
          if (cyc !== e.due || ram0[e.addr] !== e.data) begin
            n_err++; $display("FAIL write_done got cyc %0d ram %h want cyc %0d ram %h", cyc, ram0[e.addr], e.due, e.data);
          end
        end
      end
      tick();
    end
    n_cmp++; if (wcnt != W0) begin n_err++; $display("FAIL write_width got %0d want %0d", wcnt, W0); end
    n_cmp++; if (ndone != 1) begin n_err++; $display("FAIL write_done_count got %0d want 1", ndone); end
  endtask

  task automatic test_priority();
    exp_t e;
    int   s, wcnt, ndone;
    ram0[9'h0AA] = 32'hA5A5_0F0F;
    bus = 32'h0000_00AA; marin0 = 1; rd0 = 1; wr0 = 1;
    tick();
    s = cyc; marin0 = 0; rd0 = 0; wr0 = 0; wcnt = 0; ndone = 0;
    sbq.push_back('{addr: 9'h0AA, data: 32'hA5A5_0F0F, due: s + W0 + 1, wr: 1'b0});
    for (int i = 1; i <= W0 + 3; i++) begin
      if (rwr0) wcnt++;
      if (done0) begin
        ndone++;
        n_cmp++;
        if (sbq.size() == 0) begin n_err++; $display("FAIL prio_extra_done at cyc%0d", i); end
        else begin
          e = sbq.pop_front();
          if (cyc !== e.due || mdr0 !== e.data) begin
            n_err++; $display("FAIL prio_done got cyc %0d mdr %h want cyc %0d mdr %h", cyc, mdr0, e.due, e.data);
          end
        end
      end
      tick();
    end
    n_cmp++; if (wcnt != 0) begin n_err++; $display("FAIL prio_write_seen got %0d want 0", wcnt); end
    n_cmp++; if (ndone != 1) begin n_err++; $display("FAIL prio_done_count got %0d want 1", ndone); end
  endtask

  task automatic test_ignore_busy();
    exp_t e;
    int   s, rcnt, ndone;
    ram0[9'h020] = 32'h600D_F00D;
    ram0[9'h010] = 32'hBAD0_0010;
    bus = 32'h0000_0020; marin0 = 1; rd0 = 1;
    tick();
    s = cyc; marin0 = 0; rcnt = 0; ndone = 0;
    sbq.push_back('{addr: 9'h020, data: 32'h600D_F00D, due: s + W0 + 1, wr: 1'b0});
    for (int i = 1; i <= W0 + 3; i++) begin
      if (rrd0) rcnt++;
      if (i <= W0 + 2) begin
        n_cmp++; if (addr0 !== 9'h020) begin n_err++; $display("FAIL busy_mar cyc%0d got %h want 020", i, addr0); end
      end
      marin0 = 0;
      if (i == 2) begin bus = 32'h0000_0010; marin0 = 1; end
      if (done0) begin
        ndone++; rd0 = 0;
        n_cmp++;
        if (sbq.size() == 0) begin n_err++; $display("FAIL busy_extra_done at cyc%0d", i); end
        else begin
          e = sbq.pop_front();
          if (cyc !== e.due || mdr0 !== e.data) begin
            n_err++; $display("FAIL busy_done got cyc %0d mdr %h want cyc %0d mdr %h", cyc, mdr0, e.due, e.data);
          end
        end
      end
      tick();
    end
    rd0 = 0; marin0 = 0;
    n_cmp++; if (rcnt != W0) begin n_err++; $display("FAIL busy_read_cycles got %0d want %0d", rcnt, W0); end
    n_cmp++; if (ndone != 1 || busy0 !== 1'b0) begin n_err++; $display("FAIL busy_single got %0d dones busy %b want 1 / 0", ndone, busy0); end
  endtask

  task automatic test_clr_abort();
    int ndone;
    bus = 32'hCAFE_00F0; marin0 = 1; mdrin0 = 1; wr0 = 1;
    tick();
    marin0 = 0; mdrin0 = 0; wr0 = 0; ndone = 0;
    tick();
    n_cmp++; if (rwr0 !== 1'b1) begin n_err++; $display("FAIL abort_strobe1 got %b want 1", rwr0); end
    tick();
    n_cmp++; if (rwr0 !== 1'b1 || addr0 !== 9'h0F0) begin n_err++; $display("FAIL abort_strobe2 got %b@%h want 1@0f0", rwr0, addr0); end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_cmp++; if ({rrd0, rwr0, busy0, done0} !== 4'b0) begin n_err++; $display("FAIL abort_ctl got %b want 0000", {rrd0, rwr0, busy0, done0}); end
    n_cmp++; if (addr0 !== 9'h0 || mdr0 !== 32'h0) begin n_err++; $display("FAIL abort_regs got %h/%h want 000/00000000", addr0, mdr0); end
    for (int i = 0; i < 4; i++) begin
      if (done0 || busy0) ndone++;
      tick();
    end
    n_cmp++; if (ndone != 0) begin n_err++; $display("FAIL abort_done got %0d activity cycles want 0", ndone); end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    bit          pre;
    logic [8:0]  a;
    int          pushes, ndone;
    ram1[9'h003] = 32'h1111_0003;
    ram1[9'h004] = 32'h2222_0004;
    ram1[9'h005] = 32'h3333_0005;
    bus = 32'h0000_0003; marin1 = 1;
    tick();
    marin1 = 0; rd1 = 1; pushes = 0; ndone = 0;
    for (int k = 0; k < 16; k++) begin
      pre = (busy1 === 1'b0) && (rd1 === 1'b1);
      a   = addr1;
      tick();
      if (pre) begin
        sbq.push_back('{addr: a, data: ram1[a], due: cyc + W1 + 1, wr: 1'b0});
        pushes++;
        if (pushes == 3) rd1 = 0;
      end
      marin1 = 0;
      if (done1) begin
        ndone++;
        bus = 32'(addr1) + 32'd1; marin1 = 1;
        n_cmp++;
        if (sbq.size() == 0) begin n_err++; $display("FAIL b2b_extra_done at k%0d", k); end
        else begin
          e = sbq.pop_front();
          if (cyc !== e.due || mdr1 !== e.data) begin
            n_err++; $display("FAIL b2b_done got cyc %0d mdr %h want cyc %0d mdr %h", cyc, mdr1, e.due, e.data);
          end
        end
      end
    end
    rd1 = 0; marin1 = 0;
    n_cmp++; if (ndone != 3 || sbq.size() != 0) begin n_err++; $display("FAIL b2b_count got %0d dones %0d pending want 3 / 0", ndone, sbq.size()); end
    n_cmp++; if (ovl != 0) begin n_err++; $display("FAIL strobe_overlap got %0d cycles want 0", ovl); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram0[i] = 32'h0;
      ram1[i] = 32'h0;
    end
    tick();
    test_reset();
    test_read();
    test_write();
    test_priority();
    test_ignore_busy();
    test_clr_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
